// File: rtl/display_frame_ctrl.sv
// Frame sequencer for the garbled display datapath: holds msg/z config, owns the
// per-frame evaluator seed (LFSR), captures the pixel vector after a settle time
// and streams it out in CHUNK-bit beats over valid/ready.
// Ports: clk/rst (sync, active-high); cfg_* config offer (accepted in IDLE only);
//   seed_load/seed_value LFSR load; start/abort frame control; busy status;
//   dp_msg/dp_z/dp_rnd drive the datapath, dp_pix returns its pixels;
//   out_valid/out_ready/out_data/out_last beat stream; frame_cnt completed frames.
module display_frame_ctrl #(
  parameter int WIDTH         = 120,
  parameter int HEIGHT        = 52,
  parameter int NB_SEGMENTS   = 70,
  parameter int CHUNK         = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [NB_SEGMENTS-1:0]    cfg_msg,
  input  logic                      cfg_z,
  input  logic                      seed_load,
  input  logic [15:0]               seed_value,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic [NB_SEGMENTS-1:0]    dp_msg,
  output logic                      dp_z,
  output logic [15:0]               dp_rnd,
  input  logic [WIDTH*HEIGHT-1:0]   dp_pix,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHUNK-1:0]          out_data,
  output logic                      out_last,
  output logic [15:0]               frame_cnt
);

  localparam int NPIX   = WIDTH * HEIGHT;
  localparam int NCHUNK = (NPIX + CHUNK - 1) / CHUNK;
  localparam int PADW   = NCHUNK * CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int SCW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [IDXW-1:0] LAST_IDX    = IDXW'(NCHUNK - 1);
  localparam logic [SCW-1:0]  SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [NB_SEGMENTS-1:0]   msg_q, msg_d;
  logic                     z_q, z_d;
  logic                     cfg_loaded_q, cfg_loaded_d;
  logic [15:0]              lfsr_q, lfsr_d;
  logic [15:0]              frame_cnt_q, frame_cnt_d;
  logic [PADW-1:0]          pix_q, pix_d;
  logic [IDXW-1:0]          idx_q, idx_d;
  logic [SCW-1:0]           settle_q, settle_d;

  logic                     cfg_acc;
  logic [PADW-1:0]          pix_ext;
  logic [CHUNK-1:0]         chunk_a [NCHUNK];
  logic [15:0]              lfsr_step;

  // Pad the pixel vector to a whole number of beats; padding bits read as zero.
  always_comb begin
    pix_ext            = '0;
    pix_ext[NPIX-1:0]  = dp_pix;
  end

  always_comb begin
    for (int i = 0; i < NCHUNK; i++) begin
      chunk_a[i] = pix_q[i*CHUNK +: CHUNK];
    end
  end

  // Fibonacci LFSR, taps 16/14/13/11.
  assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  assign cfg_acc = cfg_valid && (state_q == S_IDLE);

  always_comb begin
    state_d      = state_q;
    msg_d        = msg_q;
    z_d          = z_q;
    cfg_loaded_d = cfg_loaded_q;
    lfsr_d       = lfsr_q;
    frame_cnt_d  = frame_cnt_q;
    pix_d        = pix_q;
    idx_d        = idx_q;
    settle_d     = settle_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_acc) begin
          msg_d        = cfg_msg;
          z_d          = cfg_z;
          cfg_loaded_d = 1'b1;
        end
        // An all-zero LFSR would lock up, so zero maps to the reset seed.
        if (seed_load) begin
          lfsr_d = (seed_value == 16'h0000) ? 16'h0001 : seed_value;
        end
        // Config accepted this cycle counts as loaded, so one-shot setup+start works.
        if (start && (cfg_loaded_q || cfg_acc)) begin
          state_d  = S_SETTLE;
          settle_d = '0;
        end
      end

      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (settle_q == SETTLE_LAST) begin
          pix_d   = pix_ext;
          idx_d   = '0;
          state_d = S_STREAM;
        end else begin
          settle_d = settle_q + SCW'(1);
        end
      end

      S_STREAM: begin
        // Completion takes priority over a coincident abort.
        if (out_ready && (idx_q == LAST_IDX)) begin
          state_d     = S_IDLE;
          lfsr_d      = lfsr_step;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else if (abort) begin
          state_d = S_IDLE;
        end else if (out_ready) begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      msg_q        <= '0;
      z_q          <= 1'b0;
      cfg_loaded_q <= 1'b0;
      lfsr_q       <= 16'h0001;
      frame_cnt_q  <= 16'h0000;
      pix_q        <= '0;
      idx_q        <= '0;
      settle_q     <= '0;
    end else begin
      state_q      <= state_d;
      msg_q        <= msg_d;
      z_q          <= z_d;
      cfg_loaded_q <= cfg_loaded_d;
      lfsr_q       <= lfsr_d;
      frame_cnt_q  <= frame_cnt_d;
      pix_q        <= pix_d;
      idx_q        <= idx_d;
      settle_q     <= settle_d;
    end
  end

  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_STREAM);
  assign out_data  = (state_q == S_STREAM) ? chunk_a[idx_q] : '0;
  assign out_last  = (state_q == S_STREAM) && (idx_q == LAST_IDX);
  assign dp_msg    = msg_q;
  assign dp_z      = z_q;
  assign dp_rnd    = lfsr_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_display_frame_ctrl.sv
module tb_display_frame_ctrl;

  localparam int W  = 5;
  localparam int H  = 3;
  localparam int NS = 8;
  localparam int CK = 4;
  localparam int SC = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [NS-1:0]  cfg_msg;
  logic           cfg_z;
  logic           seed_load;
  logic [15:0]    seed_value;
  logic           start;
  logic           abort;
  logic           busy;
  logic [NS-1:0]  dp_msg;
  logic           dp_z;
  logic [15:0]    dp_rnd;
  logic [W*H-1:0] dp_pix;
  logic           out_valid;
  logic           out_ready;
  logic [CK-1:0]  out_data;
  logic           out_last;
  logic [15:0]    frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected beats: {last, data}
  logic [CK:0] exp_q [$];

  always #5 clk = ~clk;

  display_frame_ctrl #(
    .WIDTH(W), .HEIGHT(H), .NB_SEGMENTS(NS), .CHUNK(CK), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_msg(cfg_msg), .cfg_z(cfg_z),
    .seed_load(seed_load), .seed_value(seed_value),
    .start(start), .abort(abort), .busy(busy),
    .dp_msg(dp_msg), .dp_z(dp_z), .dp_rnd(dp_rnd), .dp_pix(dp_pix),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .frame_cnt(frame_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [15:0] pix16, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      exp_q.push_back({(i == 3), pix16[i*4 +: 4]});
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      cycle();
      k++;
    end
    n_tests++;
    if (busy) begin
      n_fail++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles, required 0", busy, budget);
    end
  endtask

  // Monitor: every accepted beat is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL beat_unexpected: got data %0h last %0d, required no beat", out_data, out_last);
      end else begin
        logic [CK:0] e;
        e = exp_q.pop_front();
        chk("beat_data", 32'(out_data), 32'(e[CK-1:0]));
        chk("beat_last", 32'(out_last), 32'(e[CK]));
      end
    end
  end

  initial begin
    rst = 1'b1; cfg_valid = 0; cfg_msg = '0; cfg_z = 0; seed_load = 0; seed_value = '0;
    start = 0; abort = 0; dp_pix = '0; out_ready = 0;
    cycle(); cycle();
    rst = 1'b0;
    cycle();

    // Reset state
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_dp_msg", 32'(dp_msg), 0);
    chk("rst_dp_z", 32'(dp_z), 0);
    chk("rst_dp_rnd", 32'(dp_rnd), 32'h0001);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);

    // start with no config is ignored
    start = 1; cycle(); start = 0; cycle();
    chk("nocfg_busy", 32'(busy), 0);

    // Seed load, including zero mapping to 0001
    seed_load = 1; seed_value = 16'hACE1; cycle(); seed_load = 0;
    chk("seed_ace1", 32'(dp_rnd), 32'hACE1);
    seed_load = 1; seed_value = 16'h0000; cycle(); seed_load = 0;
    chk("seed_zero", 32'(dp_rnd), 32'h0001);
    seed_load = 1; seed_value = 16'hACE1; cycle(); seed_load = 0;

    // Config
    cfg_valid = 1; cfg_msg = 8'hA5; cfg_z = 1; cycle(); cfg_valid = 0;
    chk("cfg_msg", 32'(dp_msg), 32'hA5);
    chk("cfg_z", 32'(dp_z), 1);

    // Frame 1: streaming with ready held high
    dp_pix = 15'h5A3C; out_ready = 1;
    push_frame(16'h5A3C, 4);
    start = 1; cycle(); start = 0;                       // t+1
    chk("f1_busy", 32'(busy), 1);
    chk("f1_cfg_ready", 32'(cfg_ready), 0);
    chk("f1_valid_t1", 32'(out_valid), 0);
    seed_load = 1; seed_value = 16'h1234; cycle(); seed_load = 0;   // t+2
    chk("f1_valid_t2", 32'(out_valid), 0);
    chk("busy_seed_ignored", 32'(dp_rnd), 32'hACE1);
    cycle();                                             // t+3
    chk("f1_valid_t3", 32'(out_valid), 1);
    chk("f1_rnd_stream", 32'(dp_rnd), 32'hACE1);
    wait_idle(20);
    chk("f1_rnd_after", 32'(dp_rnd), 32'h59C3);
    chk("f1_cnt", 32'(frame_cnt), 1);
    chk("f1_valid_idle", 32'(out_valid), 0);

    // Frame 2: backpressure during beat 1
    push_frame(16'h5A3C, 4);
    start = 1; cycle(); start = 0; cycle(); cycle();     // t+3, beat 0 goes this cycle
    cycle();                                             // t+4, beat 1 presented
    out_ready = 0;
    chk("bp_data0", 32'(out_data), 32'h3);
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data", 32'(out_data), 32'h3);
      chk("bp_last", 32'(out_last), 0);
    end
    out_ready = 1;
    wait_idle(20);
    chk("f2_cnt", 32'(frame_cnt), 2);
    chk("f2_rnd", 32'(dp_rnd), 32'hB387);

    // Frame 3: abort after beat 1 accepted, then replay
    out_ready = 0;
    exp_q.push_back({1'b0, 4'hC});
    exp_q.push_back({1'b0, 4'h3});
    start = 1; cycle(); start = 0; cycle(); cycle();     // t+3
    out_ready = 1; cycle(); cycle();                     // beats 0 and 1 accepted
    chk("ab_pre_data", 32'(out_data), 32'hA);
    out_ready = 0; abort = 1; cycle(); abort = 0;
    chk("ab_valid", 32'(out_valid), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_cnt", 32'(frame_cnt), 2);
    chk("ab_rnd", 32'(dp_rnd), 32'hB387);
    out_ready = 1;
    push_frame(16'h5A3C, 4);
    start = 1; cycle(); start = 0;
    wait_idle(20);
    chk("f3_cnt", 32'(frame_cnt), 3);
    chk("f3_rnd", 32'(dp_rnd), 32'h670F);

    // abort in IDLE does nothing
    abort = 1; cycle(); abort = 0; cycle();
    chk("idle_abort_cnt", 32'(frame_cnt), 3);
    chk("idle_abort_rnd", 32'(dp_rnd), 32'h670F);

    // Frame 4: cfg + seed + start in the same cycle
    dp_pix = 15'h1234;
    push_frame(16'h1234, 4);
    cfg_valid = 1; cfg_msg = 8'h3C; cfg_z = 0; seed_load = 1; seed_value = 16'hBEEF; start = 1;
    cycle();
    cfg_valid = 0; seed_load = 0; start = 0;
    chk("f4_msg", 32'(dp_msg), 32'h3C);
    chk("f4_z", 32'(dp_z), 0);
    chk("f4_rnd", 32'(dp_rnd), 32'hBEEF);
    chk("f4_busy", 32'(busy), 1);
    wait_idle(20);
    chk("f4_cnt", 32'(frame_cnt), 4);
    chk("f4_rnd_after", 32'(dp_rnd), 32'h7DDE);

    cycle();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
